// File: rtl/tb4004_pkg.sv
// tb4004_pkg
// Shared definitions for the 4004-style fetch path: machine-cycle phase
// encoding, the opcodes that take a second instruction word, and a helper
// that classifies a first word as one- or two-word.
package tb4004_pkg;

  // Eight clocks per machine cycle; the encoding is what appears on 'cycle'.
  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;

  // opr==2 shares its upper nibble between FIM (opa even) and SRC (opa odd),
  // so only the even form fetches a second word.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    logic result;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: result = 1'b1;
      OPR_FIM:                            result = ~opa[0];
      default:                            result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// cycle_counter
// Machine-cycle phase counter. Steps A1..X3 once per clock and wraps back
// to A1; a new machine cycle only starts if 'run' is high while at A1.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset, forces A1
//   run   - permission to leave A1; ignored in every other phase
//   cycle - current phase (A1=0 .. X3=7)
module cycle_counter
  import tb4004_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [2:0] cycle
);

  phase_t state, state_next;

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= A1;
    end else begin
      state <= state_next;
    end
  end

  // Once a machine cycle has begun it always runs to X3; only A1 may stall.
  always_comb begin
    state_next = state;
    if (state == A1 && !run) begin
      state_next = A1;
    end else begin
      state_next = phase_t'(state + 3'd1);
    end
  end

  assign cycle = state;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction fetch sequencer. Presents the PC to the ROM for a whole
// machine cycle, captures the returned nibbles into opr/opa (first word)
// or arg (second word), tracks two-word instructions and advances or
// reloads the PC at X3.
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   run           - start a new machine cycle (looked at only in A1)
//   rom_nibble    - ROM data nibble for the current phase
//   jump_en       - at X3, load PC from jump_addr instead of incrementing
//   jump_addr     - jump target
//   rom_addr      - ROM byte address (the PC)
//   cycle         - machine-cycle phase
//   sync          - X3 and another machine cycle will follow
//   opr, opa      - first instruction word, upper/lower nibble
//   arg           - second instruction word
//   second_word   - the current machine cycle fetches a second word
//   instr_valid   - one-clock pulse in X1 when a full instruction is held
module fetch_sequencer
  import tb4004_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  rom_nibble,
  input  logic        jump_en,
  input  logic [11:0] jump_addr,
  output logic [11:0] rom_addr,
  output logic [2:0]  cycle,
  output logic        sync,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [7:0]  arg,
  output logic        second_word,
  output logic        instr_valid
);

  logic [11:0] pc;
  phase_t      phase;

  cycle_counter u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .cycle (cycle)
  );

  assign phase    = phase_t'(cycle);
  assign rom_addr = pc;

  // PC and instruction latches. Nothing changes outside M1/M2/X3, so a
  // stall at A1 leaves the whole fetch state untouched. The ROM has had a
  // full clock after the address settled by the time M1 samples it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      opr         <= 4'h0;
      opa         <= 4'h0;
      arg         <= 8'h00;
      second_word <= 1'b0;
    end else begin
      case (phase)
        M1: begin
          if (second_word) begin
            arg[7:4] <= rom_nibble;
          end else begin
            opr <= rom_nibble;
          end
        end
        M2: begin
          if (second_word) begin
            arg[3:0] <= rom_nibble;
          end else begin
            opa <= rom_nibble;
          end
        end
        X3: begin
          // A second word is owed only after a two-word first word; after
          // the second word has been fetched the flag always clears.
          second_word <= ~second_word & is_two_word(opr, opa);
          pc          <= jump_en ? jump_addr : pc + 12'd1;
        end
        default: ;
      endcase
    end
  end

  // The instruction is complete at X1 of either a one-word fetch or the
  // second-word fetch; the first cycle of a two-word opcode stays silent.
  always_comb begin
    instr_valid = 1'b0;
    sync        = 1'b0;
    if (phase == X1) begin
      instr_valid = second_word | ~is_two_word(opr, opa);
    end
    if (phase == X3) begin
      sync = run;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A small ROM model answers the
// address with the upper nibble through M1 and the lower nibble after.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  rom_nibble;
  logic        jump_en;
  logic [11:0] jump_addr;
  logic [11:0] rom_addr;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  arg;
  logic        second_word;
  logic        instr_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom_mem [16];
  logic [7:0] rom_byte;

  fetch_sequencer #(.RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .rom_nibble  (rom_nibble),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .rom_addr    (rom_addr),
    .cycle       (cycle),
    .sync        (sync),
    .opr         (opr),
    .opa         (opa),
    .arg         (arg),
    .second_word (second_word),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: only the first 16 bytes are programmable, the rest read as NOP.
  always_comb begin
    rom_byte   = (rom_addr[11:4] == 8'h00) ? rom_mem[rom_addr[3:0]] : 8'h00;
    rom_nibble = (cycle <= 3'd3) ? rom_byte[7:4] : rom_byte[3:0];
  end

  task automatic apply_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 12'h000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Walks one full machine cycle starting at A1, observing each phase.
  task automatic run_machine_cycle(input bit jmp_at_x3, input bit jmp_elsewhere,
                                   output int pulses, output int pulse_phase,
                                   output bit sw_seen, output bit addr_stable,
                                   output bit seq_ok, output bit sync_x3,
                                   output bit sync_other);
    logic [11:0] start_addr;
    start_addr  = rom_addr;
    pulses      = 0;
    pulse_phase = -1;
    sw_seen     = second_word;
    addr_stable = 1'b1;
    seq_ok      = 1'b1;
    sync_x3     = 1'b0;
    sync_other  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cycle !== 3'(i)) seq_ok = 1'b0;
      if (rom_addr !== start_addr) addr_stable = 1'b0;
      if (instr_valid === 1'b1) begin
        pulses++;
        pulse_phase = i;
      end
      if (i == 7) sync_x3 = (sync === 1'b1);
      else if (sync !== 1'b0) sync_other = 1'b1;
      jump_en = (i == 7) ? jmp_at_x3 : jmp_elsewhere;
      @(negedge clk);
    end
    jump_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cycle !== 3'd0) begin
      n_fail++; $display("[TB] FAIL reset_cycle: got %0d want 0", cycle);
    end
    n_checks++;
    if (rom_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL reset_pc: got %h want 000", rom_addr);
    end
    n_checks++;
    if ({opr, opa, arg} !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL reset_latches: got %h want 0000", {opr, opa, arg});
    end
    n_checks++;
    if ({second_word, instr_valid, sync} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {second_word, instr_valid, sync});
    end
    rst_n = 1'b1;
    run   = 1'b0;
  endtask

  task automatic test_ldm();
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    apply_reset();
    rom_mem[0] = 8'hD5;
    run = 1'b1;
    run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (!seq || !stable) begin
      n_fail++; $display("[TB] FAIL ldm_sequence: seq_ok=%0b addr_stable=%0b want 1 1", seq, stable);
    end
    n_checks++;
    if (pulses !== 1 || pphase !== 5) begin
      n_fail++; $display("[TB] FAIL ldm_valid: got %0d pulses at %0d want 1 at 5", pulses, pphase);
    end
    n_checks++;
    if (opr !== 4'hD || opa !== 4'h5) begin
      n_fail++; $display("[TB] FAIL ldm_opr_opa: got %h%h want D5", opr, opa);
    end
    n_checks++;
    if (rom_addr !== 12'h001 || cycle !== 3'd0) begin
      n_fail++; $display("[TB] FAIL ldm_pc: got pc=%h cycle=%0d want 001 0", rom_addr, cycle);
    end
    n_checks++;
    if (sx3 !== 1'b1 || soth !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ldm_sync: got x3=%0b other=%0b want 1 0", sx3, soth);
    end
  endtask

  task automatic test_jun();
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    apply_reset();
    rom_mem[0] = 8'h40;
    rom_mem[1] = 8'h2A;
    jump_addr  = 12'h02A;
    run = 1'b1;
    // jump_en held in every phase except X3 must be ignored
    run_machine_cycle(1'b0, 1'b1, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (pulses !== 0 || sw !== 1'b0) begin
      n_fail++; $display("[TB] FAIL jun_first: got pulses=%0d sw=%0b want 0 0", pulses, sw);
    end
    n_checks++;
    if (rom_addr !== 12'h001 || second_word !== 1'b1) begin
      n_fail++; $display("[TB] FAIL jun_after_first: got pc=%h sw=%0b want 001 1", rom_addr, second_word);
    end
    run_machine_cycle(1'b1, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (sw !== 1'b1 || pulses !== 1 || pphase !== 5) begin
      n_fail++; $display("[TB] FAIL jun_second: got sw=%0b pulses=%0d at %0d want 1 1 at 5", sw, pulses, pphase);
    end
    n_checks++;
    if (arg !== 8'h2A || opr !== 4'h4 || opa !== 4'h0) begin
      n_fail++; $display("[TB] FAIL jun_words: got opr=%h opa=%h arg=%h want 4 0 2A", opr, opa, arg);
    end
    n_checks++;
    if (rom_addr !== 12'h02A || second_word !== 1'b0) begin
      n_fail++; $display("[TB] FAIL jun_target: got pc=%h sw=%0b want 02A 0", rom_addr, second_word);
    end
    rom_mem[1] = 8'h00;
  endtask

  task automatic test_pc_wrap();
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    apply_reset();
    rom_mem[0] = 8'hD5;
    jump_addr  = 12'hFFF;
    run = 1'b1;
    run_machine_cycle(1'b1, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (rom_addr !== 12'hFFF) begin
      n_fail++; $display("[TB] FAIL wrap_setup: got pc=%h want FFF", rom_addr);
    end
    run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (rom_addr !== 12'h000 || pulses !== 1) begin
      n_fail++; $display("[TB] FAIL wrap_pc: got pc=%h pulses=%0d want 000 1", rom_addr, pulses);
    end
  endtask

  task automatic test_stall();
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    int bad;
    logic [2:0] exp_cycle [6];
    exp_cycle = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0};
    apply_reset();
    rom_mem[0] = 8'hD5;
    rom_mem[1] = 8'h10;
    run = 1'b1;
    run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    run = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cycle !== 3'd0 || sync !== 1'b0 || rom_addr !== 12'h001 ||
          opr !== 4'hD || opa !== 4'h5 || second_word !== 1'b0 || instr_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("[TB] FAIL stall_hold: %0d of 10 clocks changed state, want 0", bad);
    end
    run = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cycle !== 3'd4) begin
      n_fail++; $display("[TB] FAIL stall_reach_m2: got cycle=%0d want 4", cycle);
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (cycle !== exp_cycle[i]) begin
        n_fail++; $display("[TB] FAIL stall_finish_%0d: got cycle=%0d want %0d", i, cycle, exp_cycle[i]);
      end
      if (exp_cycle[i] == 3'd7) begin
        n_checks++;
        if (sync !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stall_sync: got %0b want 0", sync);
        end
      end
    end
    n_checks++;
    if (rom_addr !== 12'h002 || opr !== 4'h1 || second_word !== 1'b1) begin
      n_fail++; $display("[TB] FAIL stall_after: got pc=%h opr=%h sw=%0b want 002 1 1", rom_addr, opr, second_word);
    end
    rom_mem[1] = 8'h00;
  endtask

  task automatic test_reset_mid_fim();
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    int stray;
    apply_reset();
    rom_mem[0] = 8'h20;
    rom_mem[1] = 8'hC3;
    run = 1'b1;
    run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    n_checks++;
    if (second_word !== 1'b1 || pulses !== 0) begin
      n_fail++; $display("[TB] FAIL fim_first: got sw=%0b pulses=%0d want 1 0", second_word, pulses);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) stray++;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) stray++;
    end
    n_checks++;
    if (cycle !== 3'd0 || rom_addr !== 12'h000 || second_word !== 1'b0 || arg !== 8'h00) begin
      n_fail++; $display("[TB] FAIL fim_abort_state: got cycle=%0d pc=%h sw=%0b arg=%h want 0 000 0 00",
                         cycle, rom_addr, second_word, arg);
    end
    rst_n = 1'b1;
    run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
    stray += pulses;
    n_checks++;
    if (stray !== 0 || sw !== 1'b0 || !seq) begin
      n_fail++; $display("[TB] FAIL fim_abort_restart: got stray=%0d sw=%0b seq_ok=%0b want 0 0 1", stray, sw, seq);
    end
    rom_mem[1] = 8'h00;
  endtask

  task automatic test_opcode_classes();
    logic [7:0] ops  [12];
    bit         twos [12];
    int pulses, pphase;
    bit sw, stable, seq, sx3, soth;
    ops  = '{8'h10, 8'h40, 8'h50, 8'h70, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'hD5, 8'h60, 8'hF0};
    twos = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
    for (int k = 0; k < 12; k++) begin
      apply_reset();
      rom_mem[0] = ops[k];
      run = 1'b1;
      run_machine_cycle(1'b0, 1'b0, pulses, pphase, sw, stable, seq, sx3, soth);
      n_checks++;
      if (second_word !== twos[k] || pulses !== (twos[k] ? 0 : 1)) begin
        n_fail++; $display("[TB] FAIL opclass_%h: got sw=%0b pulses=%0d want %0b %0d",
                           ops[k], second_word, pulses, twos[k], twos[k] ? 0 : 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
    rst_n     = 1'b0;
    run       = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 12'h000;
    test_reset();
    test_ldm();
    test_jun();
    test_pc_wrap();
    test_stall();
    test_reset_mid_fim();
    test_opcode_classes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
